// File: rtl/mode7_pkg.sv
// Shared constants and types for the Mode 7 scanline fill path.
// Geometry matches the getXY transform and the 320x240 raster.
package mode7_pkg;

   localparam int COORD_W = 16;
   localparam int COLOR_W = 8;
   localparam int LINE_W  = 320;
   localparam int LINES   = 240;
   localparam int XW      = $clog2(LINE_W);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } fill_st_t;

   typedef struct packed {
      logic          v;
      logic [XW-1:0] x;
   } wr_t;

   function automatic logic [COORD_W-1:0] next_line(
      input logic [COORD_W-1:0] n
   );
      if (n == COORD_W'(LINES - 1))
         return '0;
      return n + COORD_W'(1);
   endfunction

endpackage

// File: rtl/mode7_line_ram.sv
// Two-bank scanline store: one sync write port (fill), one sync read port (display).
// Address is {bank, x}; each bank holds LINE_W texels.
module mode7_line_ram
   import mode7_pkg::*;
(
   input  logic               clk,
   input  logic               we,
   input  logic [XW:0]        wa,
   input  logic [COLOR_W-1:0] wd,
   input  logic               re,
   input  logic [XW:0]        ra,
   output logic [COLOR_W-1:0] q
);

   logic [COLOR_W-1:0] mem [2][LINE_W];

   always_ff @(posedge clk) begin
      if (we)
         mem[wa[XW]][wa[XW-1:0]] <= wd;
   end

   always_ff @(posedge clk) begin
      if (re)
         q <= mem[ra[XW]][ra[XW-1:0]];
   end

endmodule

// File: rtl/mode7_scanline_fill.sv
// Ping-pong line buffer: fills the back bank through getXY while
// the display reads the front bank; banks swap on every line_start.
module mode7_scanline_fill
   import mode7_pkg::*;
#(
   parameter int XY_LAT = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_start,
   input  logic               line_start,
   input  logic [COORD_W-1:0] line_num,
   output logic [COORD_W-1:0] gx,
   output logic [COORD_W-1:0] gy,
   input  logic [COLOR_W-1:0] gcolor,
   input  logic               rd_en,
   input  logic [COORD_W-1:0] rd_x,
   output logic [COLOR_W-1:0] pix,
   output logic               fill_busy,
   output logic               overrun
);

   localparam logic [COORD_W-1:0] XLAST = COORD_W'(LINE_W - 1);
   localparam logic [7:0] DLAST =
      (XY_LAT > 0) ? 8'(XY_LAT - 1) : 8'd0;

   fill_st_t st, st_n;
   logic [COORD_W-1:0] gx_n, gy_n;
   logic [7:0] cnt, cnt_n;
   logic front;

   wr_t iss, wr;
   logic we;
   logic [XW:0] wa, ra;
   logic re, rd_zero;
   logic [COLOR_W-1:0] q;

   always_ff @(posedge clk) begin
      if (rst) begin
         st    <= IDLE;
         gx    <= '0;
         gy    <= '0;
         cnt   <= '0;
         front <= 1'b0;
      end else begin
         st    <= st_n;
         gx    <= gx_n;
         gy    <= gy_n;
         cnt   <= cnt_n;
         front <= front ^ line_start;
      end
   end

   // line_start restarts the fill from any state
   always_comb begin
      st_n  = st;
      gx_n  = gx;
      gy_n  = gy;
      cnt_n = cnt;
      if (line_start) begin
         st_n  = ISSUE;
         gx_n  = '0;
         gy_n  = next_line(line_num);
         cnt_n = '0;
      end else begin
         unique case (st)
            ISSUE: begin
               if (gx == XLAST)
                  st_n = (XY_LAT == 0) ? IDLE : DRAIN;
               else
                  gx_n = gx + COORD_W'(1);
            end
            DRAIN: begin
               if (cnt == DLAST)
                  st_n = IDLE;
               else
                  cnt_n = cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign iss.v = (st == ISSUE);
   assign iss.x = gx[XW-1:0];

   generate
      if (XY_LAT == 0) begin : g_comb
         assign wr = iss;
      end else begin : g_pipe
         wr_t pipe [XY_LAT];

         always_ff @(posedge clk) begin
            if (rst || line_start) begin
               for (int i = 0; i < XY_LAT; i++)
                  pipe[i] <= '0;
            end else begin
               pipe[0] <= iss;
               for (int i = 1; i < XY_LAT; i++)
                  pipe[i] <= pipe[i-1];
            end
         end

         assign wr = pipe[XY_LAT-1];
      end
   endgenerate

   // a write landing on the swap edge would hit the new front bank
   assign we = wr.v && !line_start && !rst;
   assign wa = {~front, wr.x};

   assign re = rd_en && (rd_x < COORD_W'(LINE_W));
   assign ra = {front, rd_x[XW-1:0]};

   mode7_line_ram u_ram (
      .clk (clk),
      .we  (we),
      .wa  (wa),
      .wd  (gcolor),
      .re  (re),
      .ra  (ra),
      .q   (q)
   );

   always_ff @(posedge clk) begin
      if (rst)
         rd_zero <= 1'b1;
      else if (rd_en)
         rd_zero <= !re;
   end

   assign pix = rd_zero ? '0 : q;

   always_ff @(posedge clk) begin
      if (rst)
         overrun <= 1'b0;
      else if (line_start && st != IDLE)
         overrun <= 1'b1;
      else if (frame_start)
         overrun <= 1'b0;
   end

   assign fill_busy = (st != IDLE);

endmodule

// File: tb/tb_mode7_scanline_fill.sv
// Directed bench: XY_LAT=0 and XY_LAT=3 instances share stimulus,
// each with its own getXY stub (gcolor = gx ^ gy, delayed by XY_LAT).
module tb_mode7_scanline_fill;

   int n_cmp = 0;
   int n_bad = 0;
   int lat [2] = '{0, 3};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        frame_start = 1'b0;
   logic        line_start = 1'b0;
   logic [15:0] line_num = '0;
   logic        rd_en = 1'b0;
   logic [15:0] rd_x = '0;

   logic [15:0] gx0, gy0, gx3, gy3;
   logic [7:0]  gc0, gc3, pix0, pix3;
   logic        busy0, busy3, ovr0, ovr3;
   logic [7:0]  d1, d2, d3;

   logic [15:0] gx_a [2];
   logic [15:0] gy_a [2];
   logic [7:0]  pix_a [2];
   logic        busy_a [2];
   logic        ovr_a [2];

   always #5 clk = ~clk;

   assign gc0 = gx0[7:0] ^ gy0[7:0];

   always @(posedge clk) begin
      d1 <= gx3[7:0] ^ gy3[7:0];
      d2 <= d1;
      d3 <= d2;
   end

   assign gc3 = d3;

   mode7_scanline_fill #(.XY_LAT(0)) u_lat0 (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .line_start  (line_start),
      .line_num    (line_num),
      .gx          (gx0),
      .gy          (gy0),
      .gcolor      (gc0),
      .rd_en       (rd_en),
      .rd_x        (rd_x),
      .pix         (pix0),
      .fill_busy   (busy0),
      .overrun     (ovr0)
   );

   mode7_scanline_fill #(.XY_LAT(3)) u_lat3 (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .line_start  (line_start),
      .line_num    (line_num),
      .gx          (gx3),
      .gy          (gy3),
      .gcolor      (gc3),
      .rd_en       (rd_en),
      .rd_x        (rd_x),
      .pix         (pix3),
      .fill_busy   (busy3),
      .overrun     (ovr3)
   );

   assign gx_a[0]   = gx0;
   assign gx_a[1]   = gx3;
   assign gy_a[0]   = gy0;
   assign gy_a[1]   = gy3;
   assign pix_a[0]  = pix0;
   assign pix_a[1]  = pix3;
   assign busy_a[0] = busy0;
   assign busy_a[1] = busy3;
   assign ovr_a[0]  = ovr0;
   assign ovr_a[1]  = ovr3;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_line(input int n);
      line_num   = 16'(n);
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   task automatic rd(input int x);
      rd_x  = 16'(x);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((busy0 || busy3) && k < 600) begin
         tick();
         k++;
      end
      n_cmp++;
      if (busy0 || busy3) begin
         $display("FAIL wait_idle: fill_busy=%b%b after %0d cycles, required 00",
                  busy0, busy3, k);
         n_bad++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      for (int d = 0; d < 2; d++) begin
         n_cmp += 5;
         if (gx_a[d] !== 16'd0) begin
            $display("FAIL reset_gx lat%0d: got %0d, required 0", lat[d], gx_a[d]);
            n_bad++;
         end
         if (gy_a[d] !== 16'd0) begin
            $display("FAIL reset_gy lat%0d: got %0d, required 0", lat[d], gy_a[d]);
            n_bad++;
         end
         if (pix_a[d] !== 8'd0) begin
            $display("FAIL reset_pix lat%0d: got %h, required 00", lat[d], pix_a[d]);
            n_bad++;
         end
         if (busy_a[d] !== 1'b0) begin
            $display("FAIL reset_busy lat%0d: got %b, required 0", lat[d], busy_a[d]);
            n_bad++;
         end
         if (ovr_a[d] !== 1'b0) begin
            $display("FAIL reset_ovr lat%0d: got %b, required 0", lat[d], ovr_a[d]);
            n_bad++;
         end
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fill();
      int nb [2];
      int bad [2];
      for (int d = 0; d < 2; d++) begin
         nb[d]  = 0;
         bad[d] = 0;
      end
      pulse_line(5);
      for (int i = 0; i < 400; i++) begin
         for (int d = 0; d < 2; d++) begin
            if (busy_a[d] === 1'b1)
               nb[d]++;
            if (i < 320 && gx_a[d] !== 16'(i))
               bad[d]++;
            if (gy_a[d] !== 16'd6)
               bad[d]++;
         end
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         n_cmp += 3;
         if (nb[d] != 320 + lat[d]) begin
            $display("FAIL fill_busy_len lat%0d: got %0d cycles, required %0d",
                     lat[d], nb[d], 320 + lat[d]);
            n_bad++;
         end
         if (bad[d] != 0) begin
            $display("FAIL fill_sweep lat%0d: got %0d bad gx/gy samples, required 0",
                     lat[d], bad[d]);
            n_bad++;
         end
         if (gx_a[d] !== 16'd319) begin
            $display("FAIL fill_gx_hold lat%0d: got %0d, required 319", lat[d], gx_a[d]);
            n_bad++;
         end
      end
   endtask

   task automatic test_bank_swap();
      logic [7:0] e [5];
      int xs [5];
      e  = '{8'h17, 8'h06, 8'h39, 8'h39, 8'h00};
      xs = '{17, 0, 319, 5, 320};
      pulse_line(6);
      for (int k = 0; k < 5; k++) begin
         if (k == 3) begin
            rd_x = 16'(xs[k]);
            tick();
         end else begin
            rd(xs[k]);
         end
         for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (pix_a[d] !== e[k]) begin
               $display("FAIL swap_read lat%0d x=%0d: got %h, required %h",
                        lat[d], xs[k], pix_a[d], e[k]);
               n_bad++;
            end
         end
      end
      wait_idle();
   endtask

   task automatic test_wrap();
      pulse_line(239);
      for (int d = 0; d < 2; d++) begin
         n_cmp += 3;
         if (gy_a[d] !== 16'd0) begin
            $display("FAIL wrap_gy lat%0d: got %0d, required 0", lat[d], gy_a[d]);
            n_bad++;
         end
         if (gx_a[d] !== 16'd0) begin
            $display("FAIL wrap_gx lat%0d: got %0d, required 0", lat[d], gx_a[d]);
            n_bad++;
         end
         if (ovr_a[d] !== 1'b0) begin
            $display("FAIL wrap_ovr lat%0d: got %b, required 0", lat[d], ovr_a[d]);
            n_bad++;
         end
      end
      wait_idle();
      pulse_line(0);
      rd(10);
      for (int d = 0; d < 2; d++) begin
         n_cmp += 2;
         if (pix_a[d] !== 8'h0A) begin
            $display("FAIL wrap_read lat%0d: got %h, required 0a", lat[d], pix_a[d]);
            n_bad++;
         end
         if (gy_a[d] !== 16'd1) begin
            $display("FAIL wrap_next_gy lat%0d: got %0d, required 1", lat[d], gy_a[d]);
            n_bad++;
         end
      end
      wait_idle();
   endtask

   task automatic test_overrun();
      pulse_line(20);
      repeat (100) tick();
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (gx_a[d] !== 16'd100) begin
            $display("FAIL ovr_pre_gx lat%0d: got %0d, required 100", lat[d], gx_a[d]);
            n_bad++;
         end
      end
      pulse_line(30);
      for (int d = 0; d < 2; d++) begin
         n_cmp += 3;
         if (ovr_a[d] !== 1'b1) begin
            $display("FAIL ovr_set lat%0d: got %b, required 1", lat[d], ovr_a[d]);
            n_bad++;
         end
         if (gx_a[d] !== 16'd0) begin
            $display("FAIL ovr_gx lat%0d: got %0d, required 0", lat[d], gx_a[d]);
            n_bad++;
         end
         if (gy_a[d] !== 16'd31) begin
            $display("FAIL ovr_gy lat%0d: got %0d, required 31", lat[d], gy_a[d]);
            n_bad++;
         end
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (ovr_a[d] !== 1'b0) begin
            $display("FAIL ovr_clear lat%0d: got %b, required 0", lat[d], ovr_a[d]);
            n_bad++;
         end
      end
      repeat (50) tick();
      frame_start = 1'b1;
      pulse_line(30);
      frame_start = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (ovr_a[d] !== 1'b1) begin
            $display("FAIL ovr_set_wins lat%0d: got %b, required 1", lat[d], ovr_a[d]);
            n_bad++;
         end
      end
      wait_idle();
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (ovr_a[d] !== 1'b1) begin
            $display("FAIL ovr_sticky lat%0d: got %b, required 1", lat[d], ovr_a[d]);
            n_bad++;
         end
      end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      pulse_line(31);
      rd(100);
      for (int d = 0; d < 2; d++) begin
         n_cmp += 2;
         if (ovr_a[d] !== 1'b0) begin
            $display("FAIL ovr_idle_clear lat%0d: got %b, required 0", lat[d], ovr_a[d]);
            n_bad++;
         end
         if (pix_a[d] !== 8'h7B) begin
            $display("FAIL ovr_refill_read lat%0d: got %h, required 7b", lat[d], pix_a[d]);
            n_bad++;
         end
      end
      wait_idle();
   endtask

   task automatic test_rst_midfill();
      int xs [4];
      logic [7:0] e0 [4];
      logic [7:0] e3 [4];
      logic [7:0] ex;
      xs = '{20, 46, 48, 50};
      e0 = '{8'h3D, 8'h07, 8'h19, 8'h2D};
      e3 = '{8'h3D, 8'h07, 8'h2F, 8'h2D};
      pulse_line(40);
      repeat (50) tick();
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (gx_a[d] !== 16'd50) begin
            $display("FAIL rstm_pre_gx lat%0d: got %0d, required 50", lat[d], gx_a[d]);
            n_bad++;
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_cmp += 4;
         if (busy_a[d] !== 1'b0) begin
            $display("FAIL rstm_busy lat%0d: got %b, required 0", lat[d], busy_a[d]);
            n_bad++;
         end
         if (gx_a[d] !== 16'd0) begin
            $display("FAIL rstm_gx lat%0d: got %0d, required 0", lat[d], gx_a[d]);
            n_bad++;
         end
         if (gy_a[d] !== 16'd0) begin
            $display("FAIL rstm_gy lat%0d: got %0d, required 0", lat[d], gy_a[d]);
            n_bad++;
         end
         if (pix_a[d] !== 8'd0) begin
            $display("FAIL rstm_pix lat%0d: got %h, required 00", lat[d], pix_a[d]);
            n_bad++;
         end
      end
      repeat (10) tick();
      for (int k = 0; k < 4; k++) begin
         rd(xs[k]);
         for (int d = 0; d < 2; d++) begin
            ex = (d == 0) ? e0[k] : e3[k];
            n_cmp++;
            if (pix_a[d] !== ex) begin
               $display("FAIL rstm_read lat%0d x=%0d: got %h, required %h",
                        lat[d], xs[k], pix_a[d], ex);
               n_bad++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_bank_swap();
      test_wrap();
      test_overrun();
      test_rst_midfill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
